// File: rtl/bo_datapath.sv
// rtl/bo_datapath.sv - X/H/S register datapath around one shared add/multiply ALU; optional macro BO_DATAPATH_SATURATE_EN
module bo_datapath #(
    parameter int WIDTH  = 8,
    parameter int COEF_A = 3,
    parameter int COEF_B = 5,
    parameter int COEF_C = 2,
    parameter int COEF_D = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] x_in,
    input  logic             LX,
    input  logic             LH,
    input  logic             LS,
    input  logic             Hula,
    input  logic [1:0]       M0,
    input  logic [1:0]       M1,
    input  logic [1:0]       M2,
    output logic [WIDTH-1:0] x_q,
    output logic [WIDTH-1:0] h_q,
    output logic [WIDTH-1:0] s_q,
    output logic             valid,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] CA = WIDTH'(COEF_A);
    localparam logic [WIDTH-1:0] CB = WIDTH'(COEF_B);
    localparam logic [WIDTH-1:0] CC = WIDTH'(COEF_C);
    localparam logic [WIDTH-1:0] CD = WIDTH'(COEF_D);

    logic [WIDTH-1:0]   coef;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] full;
    logic               ovf_cond;
    logic [WIDTH-1:0]   alu_res;

    logic [WIDTH-1:0]   x_d;
    logic [WIDTH-1:0]   h_d;
    logic [WIDTH-1:0]   s_d;
    logic               valid_d;
    logic               valid_q;
    logic               ovf_d;
    logic               ovf_q;

    // Operand muxes: coefficient table, then A and B selects over coef/X/H/S
    always_comb begin
        coef = CA;
        op_a = '0;
        op_b = '0;
        unique case (M0)
            2'b00: coef = CA;
            2'b01: coef = CB;
            2'b10: coef = CC;
            default: coef = CD;
        endcase
        unique case (M1)
            2'b00: op_a = coef;
            2'b01: op_a = x_q;
            2'b10: op_a = h_q;
            default: op_a = s_q;
        endcase
        unique case (M2)
            2'b00: op_b = x_q;
            2'b01: op_b = coef;
            2'b10: op_b = s_q;
            default: op_b = h_q;
        endcase
    end

    // Shared ALU: double-width result so any carry or high product bits flag overflow
    always_comb begin
        a_ext    = {{WIDTH{1'b0}}, op_a};
        b_ext    = {{WIDTH{1'b0}}, op_b};
        full     = Hula ? (a_ext * b_ext) : (a_ext + b_ext);
        ovf_cond = |full[2*WIDTH-1:WIDTH];
`ifdef BO_DATAPATH_SATURATE_EN
        alu_res  = ovf_cond ? {WIDTH{1'b1}} : full[WIDTH-1:0];
`else
        alu_res  = full[WIDTH-1:0];
`endif
    end

    // Next-state: independent load enables; a set of valid/ovf beats an LX clear
    always_comb begin
        x_d     = LX ? x_in : x_q;
        h_d     = LH ? alu_res : h_q;
        s_d     = LS ? alu_res : s_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        if (LX) begin
            valid_d = 1'b0;
            ovf_d   = 1'b0;
        end
        if (LS) begin
            valid_d = 1'b1;
        end
        if ((LH || LS) && ovf_cond) begin
            ovf_d = 1'b1;
        end
    end

    // State registers, cleared immediately by reset even mid-sequence
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q     <= '0;
            h_q     <= '0;
            s_q     <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            x_q     <= x_d;
            h_q     <= h_d;
            s_q     <= s_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign valid = valid_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_bo_datapath.sv
// tb/tb_bo_datapath.sv - randomized self-checking bench for bo_datapath against an arithmetic reference model
module tb_bo_datapath;

    localparam int W   = 8;
    localparam int MOD = 256;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] x_in = '0;
    logic         LX = 1'b0, LH = 1'b0, LS = 1'b0, Hula = 1'b0;
    logic [1:0]   M0 = '0, M1 = '0, M2 = '0;
    logic [W-1:0] x_q, h_q, s_q;
    logic         valid, ovf;

    int n_total = 0;
    int n_bad   = 0;

    int unsigned m_x = 0, m_h = 0, m_s = 0, m_v = 0, m_o = 0;
    int unsigned coefs[4] = '{3, 5, 2, 7};

    always #5 clk = ~clk;

    bo_datapath #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .x_in(x_in),
        .LX(LX), .LH(LH), .LS(LS), .Hula(Hula),
        .M0(M0), .M1(M1), .M2(M2),
        .x_q(x_q), .h_q(h_q), .s_q(s_q), .valid(valid), .ovf(ovf)
    );

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".x"}, x_q, m_x);
        check({tag, ".h"}, h_q, m_h);
        check({tag, ".s"}, s_q, m_s);
        check({tag, ".valid"}, valid, m_v);
        check({tag, ".ovf"}, ovf, m_o);
    endtask

    // One clocked operation: drive at negedge, model the edge, compare 1 time unit after it
    task automatic step(input string tag, input logic lx, input logic lh, input logic ls,
                        input logic hula, input logic [1:0] m0, input logic [1:0] m1,
                        input logic [1:0] m2, input logic [W-1:0] xin);
        int unsigned c, a, b, full, res;
        int unsigned srca[4];
        int unsigned srcb[4];
        bit          over;
        @(negedge clk);
        LX = lx; LH = lh; LS = ls; Hula = hula; M0 = m0; M1 = m1; M2 = m2; x_in = xin;
        c    = coefs[m0] % MOD;
        srca = '{c, m_x, m_h, m_s};
        srcb = '{m_x, c, m_s, m_h};
        a    = srca[m1];
        b    = srcb[m2];
        full = hula ? a * b : a + b;
        over = (full >= MOD);
`ifdef BO_DATAPATH_SATURATE_EN
        res  = over ? MOD - 1 : full % MOD;
`else
        res  = full % MOD;
`endif
        @(posedge clk);
        #1;
        if (lh) m_h = res;
        if (ls) m_s = res;
        if (lx) begin
            m_x = xin;
            m_v = 0;
            m_o = 0;
        end
        if (ls) m_v = 1;
        if ((lh || ls) && over) m_o = 1;
        check_all(tag);
    endtask

    // Asynchronous reset pulse between edges; outputs must clear before the next edge
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        LX = 0; LH = 0; LS = 0;
        #1;
        reset = 1'b1;
        #1;
        m_x = 0; m_h = 0; m_s = 0; m_v = 0; m_o = 0;
        check_all(tag);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #2;
        m_x = 0; m_h = 0; m_s = 0; m_v = 0; m_o = 0;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        step("load_x", 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 8'd4);
        check("load_x.const", x_q, 4);
        step("mul_h", 0, 1, 0, 1, 2'b01, 2'b01, 2'b01, 8'd0);
        check("mul_h.const", h_q, 20);
        step("add_s", 0, 0, 1, 0, 2'b00, 2'b10, 2'b00, 8'd0);
        check("add_s.const", s_q, 24);
        check("add_s.valid_const", valid, 1);
        pulse_reset("mid_reset");

        step("reload_x", 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 8'd4);
        step("remul_h", 0, 1, 0, 1, 2'b01, 2'b01, 2'b01, 8'd0);
        step("readd_s", 0, 0, 1, 0, 2'b00, 2'b10, 2'b00, 8'd0);
        step("lx_clears_valid", 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 8'd9);
        check("lx_clears_valid.const", valid, 0);
        step("idle_hold", 0, 0, 0, 1, 2'b11, 2'b11, 2'b11, 8'd77);

        step("load_200", 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 8'd200);
        step("ovf_mul", 0, 1, 0, 1, 2'b11, 2'b01, 2'b01, 8'd0);
`ifdef BO_DATAPATH_SATURATE_EN
        check("ovf_mul.const", h_q, 255);
`else
        check("ovf_mul.const", h_q, 120);
`endif
        check("ovf_mul.flag_const", ovf, 1);
        step("ovf_sticky", 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 8'd0);
        check("ovf_sticky.const", ovf, 1);
        step("ovf_clear", 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 8'd4);
        check("ovf_clear.const", ovf, 0);

        step("lx_lh", 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 8'd10);
        check("lx_lh.h_const", h_q, 7);
        check("lx_lh.x_const", x_q, 10);
        step("lh_ls_same", 0, 1, 1, 0, 2'b10, 2'b01, 2'b01, 8'd0);
        check("lh_ls_same.hs", h_q, s_q);
        step("lx_ls_valid", 1, 0, 1, 0, 2'b00, 2'b01, 2'b00, 8'd3);
        check("lx_ls_valid.const", valid, 1);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                pulse_reset("rnd_reset");
            end else begin
                step("rnd",
                     ($urandom_range(0, 3) == 0),
                     $urandom_range(0, 1) == 1,
                     ($urandom_range(0, 2) == 0),
                     $urandom_range(0, 1) == 1,
                     2'($urandom_range(0, 3)),
                     2'($urandom_range(0, 3)),
                     2'($urandom_range(0, 3)),
                     8'($urandom_range(0, 255)));
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/bo_datapath.md
Name: bo_datapath

Overview:
- Operative datapath directly downstream of the control FSM.
- Consumes the FSM's load enables (LX, LS, LH), ALU op select (Hula) and mux selects (M0, M1, M2); holds registers X, H and S around one shared ALU.
- Evaluates polynomial-style expressions step by step under FSM control; exports the S result, a result-valid flag and a sticky overflow flag.

Parameters:
- WIDTH, 8, bit width of x_in, X, H, S and the ALU result.
- COEF_A, 3, coefficient selected by M0=00.
- COEF_B, 5, coefficient selected by M0=01.
- COEF_C, 2, coefficient selected by M0=10.
- COEF_D, 7, coefficient selected by M0=11.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- x_in  in  WIDTH  operand sampled into X when LX=1.
- LX  in  1  load X from x_in.
- LH  in  1  load H from ALU result.
- LS  in  1  load S from ALU result.
- Hula  in  1  ALU op: 0 = add, 1 = multiply.
- M0  in  2  coefficient select.
- M1  in  2  ALU operand A select.
- M2  in  2  ALU operand B select.
- x_q  out  WIDTH  X register.
- h_q  out  WIDTH  H register.
- s_q  out  WIDTH  S register (result).
- valid  out  1  result-valid flag.
- ovf  out  1  sticky overflow flag.

Behaviour:
- Single clock `clk`; reset is asynchronous and active-high, port `reset`.
- Reset, applied at any time including mid-sequence: x_q, h_q, s_q, valid and ovf go to 0 immediately, without waiting for a clock edge.
- Coefficient mux (combinational):
  - M0: 00→COEF_A, 01→COEF_B, 10→COEF_C, 11→COEF_D.
  - Each coefficient is truncated to WIDTH.
- Operand A (M1): 00→coef, 01→X, 10→H, 11→S.
- Operand B (M2): 00→X, 01→coef, 10→S, 11→H.
- ALU (combinational):
  - Full result is 2*WIDTH bits: A+B zero-extended for add, A*B for multiply.
  - Stored result is the low WIDTH bits (wrap mod 2^WIDTH).
  - Overflow condition: any upper bit of the full result is nonzero.
- Register updates, each independent, on rising clk:
  - LX: X ← x_in.
  - LH: H ← alu.
  - LS: S ← alu.
- Simultaneous loads:
  - All registers sample pre-edge values.
  - LX with LH/LS: the ALU uses the old X.
  - LH and LS together: H and S both receive the same ALU value.
  - A register whose enable is low holds its value.
- ovf:
  - Set on any edge where (LH|LS) and the overflow condition hold.
  - Cleared on an edge where LX=1 (new operation), unless the same edge also sets it; set wins.
- valid:
  - Goes to 1 on the edge where LS=1.
  - Cleared on the edge where LX=1; LS wins if both are asserted.
- Latency: one edge from enable to register output; outputs are direct register values, with no combinational path from inputs to outputs.
- All-zero control inputs (FSM idle/inicio=0): every register holds.

Optional Feature:
- Macro: BO_DATAPATH_SATURATE_EN.
- Defined: when the overflow condition holds, the stored ALU result is all-ones (2^WIDTH−1) instead of the wrapped value. ovf behaves the same.
- Undefined: stored result wraps mod 2^WIDTH.

Test Plan (WIDTH=8, default coefficients):
- Reset mid-run: X=4, H=20, S=24, valid=1; pulse reset between edges → all outputs 0 immediately, before the next edge.
- Load X: x_in=4, LX=1 for one edge → x_q=4; h_q, s_q unchanged; valid=0, ovf=0.
- Multiply to H: X=4, M0=01, M1=01, M2=01, Hula=1, LH=1 → h_q=20, ovf=0, valid=0.
- Add to S: H=20, X=4, M1=10, M2=00, Hula=0, LS=1 → s_q=24, valid=1 after that edge; next edge with LX=1, x_in=9 → valid=0, x_q=9.
- Overflow: X=200, M0=11, M1=01, M2=01, Hula=1, LH=1 → h_q=120 (1400 mod 256), ovf=1. With BO_DATAPATH_SATURATE_EN, h_q=255. ovf stays 1 until an LX edge.
- Simultaneous LX+LH: X=4, x_in=10, M0=00, M1=00, M2=00, Hula=0, LX=1, LH=1 → h_q=7 (3+old 4), x_q=10.
